pipo_shift_register: RTL and testbench



---
 rtl/pipo_shift_register.sv | 51 +++++
 tb/tb_pipo_shift_register.sv | 139 +++++++++++++
 2 files changed

// File: rtl/pipo_shift_register.sv
// Registered 8-bit logical shifter: left (multiply by 2^p2, with overflow)
// or right (truncating divide by 2^p2), one cycle of latency.
module pipo_shift_register (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] number,
    input  logic [1:0] p2,
    input  logic       md,
    output logic [7:0] result,
    output logic       ovr
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned WIDE_W = 2 * DATA_W;

    logic [WIDE_W-1:0] w_wide_left;
    logic [DATA_W-1:0] w_result_next;
    logic              w_ovr_next;
    logic [DATA_W-1:0] r_result;
    logic              r_ovr;

    // Left shift in a double-width field: the upper half collects the bits
    // that fall off the top, so any set bit there means overflow.
    always_comb begin
        w_wide_left   = {{DATA_W{1'b0}}, number} << p2;
        w_result_next = number;
        w_ovr_next    = 1'b0;
        if (md) begin
            w_result_next = w_wide_left[DATA_W-1:0];
            w_ovr_next    = |w_wide_left[WIDE_W-1:DATA_W];
        end else begin
            w_result_next = number >> p2;
            w_ovr_next    = 1'b0;
        end
    end

    // Output register; loads every edge, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= {DATA_W{1'b0}};
            r_ovr    <= 1'b0;
        end else begin
            r_result <= w_result_next;
            r_ovr    <= w_ovr_next;
        end
    end

    assign result = r_result;
    assign ovr    = r_ovr;

endmodule

// File: tb/tb_pipo_shift_register.sv
// Bench for pipo_shift_register: directed cases from the test plan followed
// by random operands checked against an arithmetic reference model.
module tb_pipo_shift_register;

    logic       clk;
    logic       rst;
    logic [7:0] number;
    logic [1:0] p2;
    logic       md;
    logic [7:0] result;
    logic       ovr;

    int checks   = 0;
    int failures = 0;

    pipo_shift_register dut (
        .clk    (clk),
        .rst    (rst),
        .number (number),
        .p2     (p2),
        .md     (md),
        .result (result),
        .ovr    (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: multiply / divide by a power of two, overflow if the
    // product does not fit in 8 bits. Returns {ovr, result}.
    function automatic logic [8:0] model(input logic [7:0] n, input logic [1:0] p,
                                          input logic m);
        int unsigned scale;
        int unsigned prod;
        scale = 1 << p;
        if (m) begin
            prod = int'(n) * scale;
            return {(prod > 255), 8'(prod % 256)};
        end
        return {1'b0, 8'(int'(n) / scale)};
    endfunction

    task automatic check(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {ovr, result};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed ovr=%b result=%h, expected ovr=%b result=%h",
                   tag, obs[8], obs[7:0], exp[8], exp[7:0]);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the next rising edge.
    task automatic apply(input logic [7:0] n, input logic [1:0] p, input logic m);
        @(negedge clk);
        number = n;
        p2     = p;
        md     = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] rn;
        logic [1:0] rp;
        logic       rm;

        rst    = 1'b0;
        number = 8'hFF;
        p2     = 2'd1;
        md     = 1'b1;
        #1 rst = 1'b1;
        #1 check("reset_immediate", 9'h000);

        // Clock edges during reset are ignored.
        repeat (3) begin
            @(posedge clk);
            #1 check("reset_hold", 9'h000);
        end

        // First load after release.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("first_load_ff_l1", {1'b1, 8'hFE});

        apply(8'b0110_1001, 2'd2, 1'b1);
        check("left_ovr", {1'b1, 8'b1010_0100});
        apply(8'b0001_1111, 2'd3, 1'b1);
        check("left_no_ovr_p3", {1'b0, 8'b1111_1000});
        apply(8'b0001_1111, 2'd0, 1'b1);
        check("left_p0", {1'b0, 8'b0001_1111});
        apply(8'b0110_1001, 2'd2, 1'b0);
        check("right_p2", {1'b0, 8'b0001_1010});
        apply(8'hFF, 2'd3, 1'b0);
        check("right_ff_p3", {1'b0, 8'h1F});
        apply(8'hA5, 2'd0, 1'b0);
        check("right_p0", {1'b0, 8'hA5});

        // Mid-cycle input change must not reach the outputs.
        #3 number = 8'h3C;
        md = 1'b1;
        p2 = 2'd3;
        #1 check("hold_mid_cycle", {1'b0, 8'hA5});

        // Mode flip between consecutive edges.
        apply(8'h81, 2'd1, 1'b1);
        check("md_flip_left", {1'b1, 8'h02});
        apply(8'h81, 2'd1, 1'b0);
        check("md_flip_right", {1'b0, 8'h40});

        // Asynchronous reset pulse between edges while result is non-zero.
        #2 rst = 1'b1;
        #1 check("async_reset_mid", 9'h000);
        @(posedge clk);
        #1 check("async_reset_edge_ignored", 9'h000);
        @(negedge clk);
        rst    = 1'b0;
        number = 8'hC3;
        p2     = 2'd2;
        md     = 1'b1;
        @(posedge clk);
        #1 check("resume_after_reset", model(8'hC3, 2'd2, 1'b1));

        // Random operands against the arithmetic model.
        for (int i = 0; i < 200; i++) begin
            rn = 8'($urandom_range(255));
            rp = 2'($urandom_range(3));
            rm = 1'($urandom_range(1));
            apply(rn, rp, rm);
            check("random", model(rn, rp, rm));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
